// File: rtl/ifid_instr_queue_pkg.sv
// Shared types and constants for the IF/ID decoupling queue.
package ifid_instr_queue_pkg;

  localparam int unsigned IFID_XLEN = 32;
  localparam logic [IFID_XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [IFID_XLEN-1:0] instr;
    logic [IFID_XLEN-1:0] pc;
    logic [IFID_XLEN-1:0] pc_link;
  } ifid_entry_t;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_PART  = 2'd1,
    Q_FULL  = 2'd2
  } ifid_q_state_e;

endpackage

// File: rtl/ifid_instr_queue_entry_ram.sv
// DEPTH-entry register array holding queued fetch entries.
// The array is left unreset; validity is tracked by the pointers and count in the top level.
module ifid_entry_ram
  import ifid_instr_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  ifid_entry_t   wdata,
  input  logic [AW-1:0] raddr,
  output ifid_entry_t   rdata
);

  ifid_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ifid_instr_queue.sv
// IF/ID instruction queue: FIFO between fetch and decode with flush on PC redirect.
// IN_READY and OUT_VALID depend only on stored state, so there is no comb path between the two sides.
module ifid_instr_queue
  import ifid_instr_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     IN_VALID,
  input  logic [XLEN-1:0]          IN_INSTR,
  input  logic [XLEN-1:0]          IN_PC,
  input  logic [XLEN-1:0]          IN_PC_LINK,
  output logic                     IN_READY,
  input  logic                     FLUSH,
  output logic                     OUT_VALID,
  output logic [XLEN-1:0]          OUT_INSTR,
  output logic [XLEN-1:0]          OUT_PC,
  output logic [XLEN-1:0]          OUT_PC_LINK,
  input  logic                     OUT_READY,
  output logic [$clog2(DEPTH):0]   OCCUPANCY
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  ifid_q_state_e q_state;
  logic          push;
  logic          pop;
  ifid_entry_t   wr_entry;
  ifid_entry_t   head;

  always_comb begin
    q_state = Q_PART;
    if (count == '0)             q_state = Q_EMPTY;
    else if (count == COUNT_FULL) q_state = Q_FULL;
  end

  assign IN_READY  = (q_state != Q_FULL);
  assign OUT_VALID = (q_state != Q_EMPTY);
  assign OCCUPANCY = count;

  assign push = IN_VALID & IN_READY & ~FLUSH;
  assign pop  = OUT_VALID & OUT_READY & ~FLUSH;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (FLUSH) begin
      // Align the read side to the write side so the queue restarts empty in place.
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign wr_entry = '{instr: IN_INSTR, pc: IN_PC, pc_link: IN_PC_LINK};

  ifid_entry_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_entry_ram (
    .clk  (CLK),
    .we   (push),
    .waddr(wr_ptr),
    .wdata(wr_entry),
    .raddr(rd_ptr),
    .rdata(head)
  );

  assign OUT_INSTR   = OUT_VALID ? head.instr   : NOP_INSTR;
  assign OUT_PC      = OUT_VALID ? head.pc      : '0;
  assign OUT_PC_LINK = OUT_VALID ? head.pc_link : '0;

`ifndef SYNTHESIS
  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (count <= COUNT_FULL);
      assert (OUT_VALID == (count != '0));
      assert (IN_READY == (count != COUNT_FULL));
    end
  end
`endif

endmodule

// File: tb/tb_ifid_instr_queue.sv
// Directed bench for ifid_instr_queue with hand-computed expectations.
module tb_ifid_instr_queue;

  logic        clk_sys;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_pc_link;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_link;
  logic        out_ready;
  logic [1:0]  occupancy;

  int n_tests = 0;
  int n_fail  = 0;

  ifid_instr_queue #(.DEPTH(2), .XLEN(32)) dut (
    .CLK        (clk_sys),
    .RST        (rst),
    .IN_VALID   (in_valid),
    .IN_INSTR   (in_instr),
    .IN_PC      (in_pc),
    .IN_PC_LINK (in_pc_link),
    .IN_READY   (in_ready),
    .FLUSH      (flush),
    .OUT_VALID  (out_valid),
    .OUT_INSTR  (out_instr),
    .OUT_PC     (out_pc),
    .OUT_PC_LINK(out_pc_link),
    .OUT_READY  (out_ready),
    .OCCUPANCY  (occupancy)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid   = v;
    in_pc      = pc;
    in_instr   = 32'h1300_0000 | pc;
    in_pc_link = pc + 32'd4;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_occ"}, {30'd0, occupancy}, 32'd0);
    check({tag, "_inrdy"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_instr"}, out_instr, 32'd0);
    check({tag, "_pc"}, out_pc, 32'd0);
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [1:0] occ);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_link"}, out_pc_link, pc + 32'd4);
    check({tag, "_instr"}, out_instr, 32'h1300_0000 | pc);
    check({tag, "_occ"}, {30'd0, occupancy}, {30'd0, occ});
  endtask

  logic [31:0] burst_in  [6] = '{32'hB0, 32'hB0, 32'hB4, 32'hB8, 32'hBC, 32'hC0};
  logic [31:0] burst_out [6] = '{32'hA0, 32'hA4, 32'hB0, 32'hB4, 32'hB8, 32'hBC};
  logic        burst_rdy [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 32'h200);
    #1;

    // Reset held with IN_VALID high
    for (int i = 0; i < 2; i++) begin
      step();
      check_empty("rst_hold");
    end

    // Single push with OUT_READY=1
    rst = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h100; in_pc_link = 32'h104;
    step();
    in_valid = 1'b0;
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_instr", out_instr, 32'h0050_0093);
    check("t1_pc", out_pc, 32'h100);
    check("t1_link", out_pc_link, 32'h104);
    check("t1_occ", {30'd0, occupancy}, 32'd1);
    step();
    check_empty("t1_pop");

    // Fill with decode stalled; third push refused
    out_ready = 1'b0;
    drive(1'b1, 32'h0);
    step();
    check_head("t2_p0", 32'h0, 2'd1);
    drive(1'b1, 32'h4);
    step();
    check_head("t2_p1", 32'h0, 2'd2);
    check("t2_full_rdy", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'h8);
    step();
    drive(1'b0, 32'h0);
    check_head("t2_p2", 32'h0, 2'd2);
    out_ready = 1'b1;
    step();
    check_head("t2_o1", 32'h4, 2'd1);
    step();
    check_empty("t2_drain");

    // Full queue with simultaneous push and pop for 6 cycles
    out_ready = 1'b0;
    drive(1'b1, 32'hA0); step();
    drive(1'b1, 32'hA4); step();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, burst_in[i]);
      check($sformatf("t3_out%0d", i), out_pc, burst_out[i]);
      check($sformatf("t3_rdy%0d", i), {31'd0, in_ready}, {31'd0, burst_rdy[i]});
      step();
      check($sformatf("t3_occ%0d", i), {30'd0, occupancy}, 32'd1);
    end
    drive(1'b0, 32'h0);
    out_ready = 1'b0;
    check_head("t3_last", 32'hC0, 2'd1);
    out_ready = 1'b1;
    step();
    check_empty("t3_drain");

    // Flush with two stored and an incoming entry
    out_ready = 1'b0;
    drive(1'b1, 32'h10); step();
    drive(1'b1, 32'h14); step();
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h40);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    check_empty("t4_flush");
    drive(1'b1, 32'h80);
    step();
    drive(1'b0, 32'h0);
    check_head("t4_after", 32'h80, 2'd1);
    step();
    check_empty("t4_drain");

    // Flush with one stored suppresses the concurrent push
    out_ready = 1'b0;
    drive(1'b1, 32'h20); step();
    flush = 1'b1;
    drive(1'b1, 32'h44);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0);
    check_empty("t4b_flush");
    out_ready = 1'b1;
    step();
    check_empty("t4b_idle");

    // Reset with two stored, together with IN_VALID and OUT_READY
    out_ready = 1'b0;
    drive(1'b1, 32'h30); step();
    drive(1'b1, 32'h34); step();
    rst = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h38);
    step();
    rst = 1'b0;
    drive(1'b0, 32'h0);
    check_empty("t5_rst");
    step();
    check_empty("t5_idle");
    drive(1'b1, 32'h50);
    step();
    drive(1'b0, 32'h0);
    check_head("t5_push", 32'h50, 2'd1);
    step();
    check_empty("t5_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
